alien_march_controller: RTL and testbench

Downstream consumer of the slow-tick counter's `one_sec` pulse. On each tick, advances the alien formation one step in a sweep: right, down, left, down, and so on. Produces the formation X/Y offsets for the alien drawing block, a step pulse for sound and animation, and a `turbo` request fed back to the tick counter when few aliens remain.

---
 rtl/alien_pkg.sv | 25 ++
 rtl/alien_march_controller.sv | 123 ++++++++++++
 tb/tb_alien_march_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alien_pkg.sv
// Shared types and default constants for the alien formation march controller.
package alien_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StMarchR,
    StMarchL,
    StDescend,
    StLanded,
    StCleared
  } march_state_t;

  localparam int unsigned OffsetW = 11;

  localparam int unsigned XMaxDefault        = 320;
  localparam int unsigned StepXDefault       = 8;
  localparam int unsigned StepYDefault       = 16;
  localparam int unsigned YLandedDefault     = 256;
  localparam int unsigned TurboThreshDefault = 8;

  function automatic logic is_marching(march_state_t s);
    return (s == StMarchR) || (s == StMarchL) || (s == StDescend);
  endfunction

endpackage

// File: rtl/alien_march_controller.sv
// Steps the alien formation right/down/left/down on each accepted tick and
// requests turbo ticks from the tick counter when few aliens remain.
module alien_march_controller
  import alien_pkg::*;
#(
  parameter int unsigned X_MAX        = XMaxDefault,
  parameter int unsigned STEP_X       = StepXDefault,
  parameter int unsigned STEP_Y       = StepYDefault,
  parameter int unsigned Y_LANDED     = YLandedDefault,
  parameter int unsigned TURBO_THRESH = TurboThreshDefault
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               pause,
  input  logic [5:0]         alive_count,
  output logic [OffsetW-1:0] offset_x,
  output logic [OffsetW-1:0] offset_y,
  output logic               dir_right,
  output logic               step,
  output logic               frame,
  output logic               landed,
  output logic               cleared,
  output logic               turbo
);

  localparam int unsigned SumW = OffsetW + 1;

  march_state_t       state_q, state_d;
  logic [OffsetW-1:0] x_q, x_d, y_q, y_d;
  logic               dir_q, dir_d;
  logic               step_q, step_d;
  logic               frame_q, frame_d;
  logic               turbo_q, turbo_d;

  logic               accept;
  logic [SumW-1:0]    x_sum;
  logic [OffsetW-1:0] y_next;
  logic               few_left;

  assign accept   = tick & ~pause;
  // Widened so the right-edge test cannot wrap.
  assign x_sum    = {1'b0, x_q} + SumW'(STEP_X);
  assign y_next   = y_q + OffsetW'(STEP_Y);
  assign few_left = (alive_count != 6'd0) && (alive_count <= 6'(TURBO_THRESH));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    frame_d = frame_q;

    case (state_q)
      StIdle, StLanded, StCleared: begin
        if (start) begin
          state_d = StMarchR;
          x_d     = '0;
          y_d     = '0;
          dir_d   = 1'b1;
        end
      end
      StMarchR, StMarchL, StDescend: begin
        if (alive_count == 6'd0) begin
          state_d = StCleared;
        end else if (accept) begin
          step_d  = 1'b1;
          frame_d = ~frame_q;
          if (state_q == StMarchR) begin
            if (x_sum > SumW'(X_MAX)) state_d = StDescend;
            else                      x_d     = x_sum[OffsetW-1:0];
          end else if (state_q == StMarchL) begin
            if (x_q < OffsetW'(STEP_X)) state_d = StDescend;
            else                        x_d     = x_q - OffsetW'(STEP_X);
          end else begin
            y_d = y_next;
            if (y_next >= OffsetW'(Y_LANDED)) begin
              state_d = StLanded;
            end else begin
              state_d = dir_q ? StMarchL : StMarchR;
              dir_d   = ~dir_q;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    turbo_d = is_marching(state_d) && few_left;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      frame_q <= 1'b0;
      turbo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      frame_q <= frame_d;
      turbo_q <= turbo_d;
    end
  end

  assign offset_x  = x_q;
  assign offset_y  = y_q;
  assign dir_right = dir_q;
  assign step      = step_q;
  assign frame     = frame_q;
  assign landed    = (state_q == StLanded);
  assign cleared   = (state_q == StCleared);
  assign turbo     = turbo_q;

endmodule

// File: tb/tb_alien_march_controller.sv
// Directed bench for alien_march_controller with hand-computed expectations.
module tb_alien_march_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [5:0]  alive_count = 6'd20;
  logic [10:0] offset_x, offset_y;
  logic        dir_right, step, frame, landed, cleared, turbo;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;

  alien_march_controller dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start      (start),
    .pause      (pause),
    .alive_count(alive_count),
    .offset_x   (offset_x),
    .offset_y   (offset_y),
    .dir_right  (dir_right),
    .step       (step),
    .frame      (frame),
    .landed     (landed),
    .cleared    (cleared),
    .turbo      (turbo)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (offset_x !== 11'd0 || offset_y !== 11'd0 || dir_right !== 1'b1 || step !== 1'b0 ||
        frame !== 1'b0 || landed !== 1'b0 || cleared !== 1'b0 || turbo !== 1'b0) begin
      errors++;
      $display("FAIL %s: x=%0d y=%0d dir=%b step=%b frame=%b landed=%b cleared=%b turbo=%b, required 0 0 1 0 0 0 0 0",
               tag, offset_x, offset_y, dir_right, step, frame, landed, cleared, turbo);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    n_acc = 0;
    check_reset_values("reset_state");
  endtask

  task automatic test_march();
    int steps = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_tick();
      if (step) steps++;
      cyc();
      if (step) steps++;
    end
    n_acc += 3;
    checks++;
    if (steps !== 3) begin errors++; $display("FAIL march_steps: got %0d required 3", steps); end
    checks++;
    if (offset_x !== 11'd24 || offset_y !== 11'd0 || dir_right !== 1'b1) begin
      errors++;
      $display("FAIL march_offsets: got x=%0d y=%0d dir=%b required 24 0 1", offset_x, offset_y, dir_right);
    end
    checks++;
    if (frame !== 1'b1) begin errors++; $display("FAIL march_frame: got %b required 1", frame); end
  endtask

  task automatic test_edge();
    // Back-to-back ticks: 24 + 37*8 = 320.
    tick = 1'b1;
    repeat (37) cyc();
    tick = 1'b0;
    n_acc += 37;
    checks++;
    if (offset_x !== 11'd320) begin errors++; $display("FAIL edge_reach: got x=%0d required 320", offset_x); end
    do_tick();
    n_acc++;
    checks++;
    if (offset_x !== 11'd320 || offset_y !== 11'd0 || step !== 1'b1) begin
      errors++;
      $display("FAIL edge_detect: got x=%0d y=%0d step=%b required 320 0 1", offset_x, offset_y, step);
    end
    do_tick();
    n_acc++;
    checks++;
    if (offset_x !== 11'd320 || offset_y !== 11'd16 || dir_right !== 1'b0) begin
      errors++;
      $display("FAIL edge_descend: got x=%0d y=%0d dir=%b required 320 16 0", offset_x, offset_y, dir_right);
    end
    do_tick();
    n_acc++;
    checks++;
    if (offset_x !== 11'd312) begin errors++; $display("FAIL edge_left: got x=%0d required 312", offset_x); end
  endtask

  task automatic test_pause();
    int steps = 0;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_tick();
      if (step) steps++;
      cyc();
    end
    checks++;
    if (steps !== 0 || offset_x !== 11'd312 || offset_y !== 11'd16 || frame !== n_acc[0]) begin
      errors++;
      $display("FAIL pause_hold: got steps=%0d x=%0d y=%0d frame=%b required 0 312 16 %b",
               steps, offset_x, offset_y, frame, n_acc[0]);
    end
    pause = 1'b0;
    do_tick();
    n_acc++;
    checks++;
    if (offset_x !== 11'd304 || step !== 1'b1) begin
      errors++;
      $display("FAIL pause_release: got x=%0d step=%b required 304 1", offset_x, step);
    end
    cyc();
    checks++;
    if (offset_x !== 11'd304 || step !== 1'b0) begin
      errors++;
      $display("FAIL pause_single: got x=%0d step=%b required 304 0", offset_x, step);
    end
  endtask

  task automatic test_landed();
    // 40 ticks finish the left row at y=32, then 14 rows of 42 ticks reach y=256.
    tick = 1'b1;
    repeat (627) cyc();
    checks++;
    if (offset_y !== 11'd240 || landed !== 1'b0) begin
      errors++;
      $display("FAIL landed_before: got y=%0d landed=%b required 240 0", offset_y, landed);
    end
    cyc();
    tick = 1'b0;
    n_acc += 628;
    checks++;
    if (offset_y !== 11'd256 || landed !== 1'b1 || offset_x !== 11'd0 || dir_right !== 1'b0) begin
      errors++;
      $display("FAIL landed_reach: got y=%0d landed=%b x=%0d dir=%b required 256 1 0 0",
               offset_y, landed, offset_x, dir_right);
    end
    tick = 1'b1;
    repeat (3) cyc();
    tick = 1'b0;
    checks++;
    if (offset_y !== 11'd256 || offset_x !== 11'd0 || step !== 1'b0 || frame !== n_acc[0]) begin
      errors++;
      $display("FAIL landed_frozen: got y=%0d x=%0d step=%b frame=%b required 256 0 0 %b",
               offset_y, offset_x, step, frame, n_acc[0]);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if (offset_x !== 11'd0 || offset_y !== 11'd0 || landed !== 1'b0 || dir_right !== 1'b1) begin
      errors++;
      $display("FAIL landed_restart: got x=%0d y=%0d landed=%b dir=%b required 0 0 0 1",
               offset_x, offset_y, landed, dir_right);
    end
  endtask

  task automatic test_turbo_clear();
    alive_count = 6'd9;
    cyc();
    checks++;
    if (turbo !== 1'b0) begin errors++; $display("FAIL turbo_nine: got %b required 0", turbo); end
    alive_count = 6'd8;
    cyc();
    checks++;
    if (turbo !== 1'b1) begin errors++; $display("FAIL turbo_eight: got %b required 1", turbo); end
    alive_count = 6'd0;
    do_tick();
    checks++;
    if (cleared !== 1'b1 || turbo !== 1'b0 || offset_x !== 11'd0 || step !== 1'b0) begin
      errors++;
      $display("FAIL clear_prio: got cleared=%b turbo=%b x=%0d step=%b required 1 0 0 0",
               cleared, turbo, offset_x, step);
    end
    alive_count = 6'd20;
  endtask

  task automatic test_start_tick_idle();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_acc = 0;
    start = 1'b1;
    tick  = 1'b1;
    cyc();
    start = 1'b0;
    tick  = 1'b0;
    checks++;
    if (offset_x !== 11'd0 || step !== 1'b0) begin
      errors++;
      $display("FAIL start_wins: got x=%0d step=%b required 0 0", offset_x, step);
    end
    do_tick();
    checks++;
    if (offset_x !== 11'd8 || step !== 1'b1 || frame !== 1'b1) begin
      errors++;
      $display("FAIL first_tick: got x=%0d step=%b frame=%b required 8 1 1", offset_x, step, frame);
    end
  endtask

  task automatic test_reset_mid();
    do_tick();
    checks++;
    if (offset_x !== 11'd16) begin errors++; $display("FAIL pre_reset: got x=%0d required 16", offset_x); end
    reset = 1'b1;
    tick  = 1'b1;
    start = 1'b1;
    pause = 1'b1;
    cyc();
    check_reset_values("reset_mid");
    reset = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    test_reset();
    test_march();
    test_edge();
    test_pause();
    test_landed();
    test_turbo_clear();
    test_start_tick_idle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
